// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressable sized load/store data memory for the RV64 MEM stage
// Registered 1-cycle reads, read-before-write on a shared cycle, faulting accesses suppressed.
module data_memory_sized #(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Mem_Addr,
  input  logic [XLEN-1:0] Write_Data,
  output logic [XLEN-1:0] Read_Data,
  output logic            read_valid,
  output logic            fault_align,
  output logic            fault_range,
  output logic            fault_illegal
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]      mem [DEPTH_BYTES];

  logic [3:0]      sz;
  logic [2:0]      low_mask;
  logic [NB-1:0]   byte_en;
  logic [AW-1:0]   base;
  logic [XLEN:0]   addr_end;
  logic            req;
  logic            bad_illegal;
  logic            bad_align;
  logic            bad_range;
  logic            flag_illegal;
  logic            flag_align;
  logic            flag_range;
  logic            any_fault;
  logic            wr_en;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] ext;

  always_comb begin
    sz       = 4'd1;
    low_mask = 3'b000;
    case (funct3[1:0])
      2'd0: begin sz = 4'd1; low_mask = 3'b000; end
      2'd1: begin sz = 4'd2; low_mask = 3'b001; end
      2'd2: begin sz = 4'd4; low_mask = 3'b011; end
      2'd3: begin sz = 4'd8; low_mask = 3'b111; end
    endcase
  end

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = (i < int'(sz));
    end
  end

  // End address is computed one bit wider so addresses near 2^XLEN cannot wrap into range.
  assign addr_end    = {1'b0, Mem_Addr} + {{(XLEN-3){1'b0}}, sz};
  assign base        = Mem_Addr[AW-1:0];
  assign req         = MemRead | MemWrite;

  // A combined read+write takes the store rule, which rejects every 1xx encoding.
  assign bad_illegal = (MemWrite && funct3[2]) || (MemRead && (funct3 == 3'b111));
  assign bad_align   = |(Mem_Addr[2:0] & low_mask);
  assign bad_range   = addr_end > (XLEN+1)'(DEPTH_BYTES);

  assign flag_illegal = req && bad_illegal;
  assign flag_align   = req && !bad_illegal && bad_align;
  assign flag_range   = req && !bad_illegal && !bad_align && bad_range;
  assign any_fault    = flag_illegal | flag_align | flag_range;
  assign wr_en        = MemWrite && !any_fault && !reset;

  // Bytes beyond the access size wrap inside the array; they are masked off below.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) begin
      raw[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_comb begin
    ext = '0;
    case (funct3)
      3'b000: ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001: ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010: ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b011: ext = raw;
      3'b100: ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101: ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      3'b110: ext = {{(XLEN-32){1'b0}}, raw[31:0]};
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Read_Data     <= '0;
      read_valid    <= 1'b0;
      fault_align   <= 1'b0;
      fault_range   <= 1'b0;
      fault_illegal <= 1'b0;
    end else begin
      read_valid    <= MemRead;
      fault_align   <= flag_align;
      fault_range   <= flag_range;
      fault_illegal <= flag_illegal;
      if (MemRead) begin
        Read_Data <= any_fault ? '0 : ext;
      end
    end
  end

  // Nonblocking update gives read-before-write when a load shares the cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[base + AW'(i)] <= Write_Data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - scoreboard bench for data_memory_sized against a byte-array model
module tb_data_memory_sized;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] Mem_Addr = 64'd0;
  logic [63:0] Write_Data = 64'd0;
  logic [63:0] Read_Data;
  logic        read_valid;
  logic        fault_align;
  logic        fault_range;
  logic        fault_illegal;

  data_memory_sized #(.XLEN(64), .DEPTH_BYTES(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .Read_Data(Read_Data), .read_valid(read_valid), .fault_align(fault_align),
    .fault_range(fault_range), .fault_illegal(fault_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic        fa;
    logic        fr;
    logic        fi;
    logic [63:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mmem [DEPTH];
  logic [63:0] m_rd = 64'd0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: sizes, faults and extension computed arithmetically from the access rules.
  function automatic exp_t model_step(input logic r, input logic mr, input logic mw,
                                      input logic [2:0] f3, input logic [63:0] a,
                                      input logic [63:0] wd);
    exp_t        e;
    int          sz;
    logic        ill, mis, oor, flt;
    logic [63:0] v;
    e = '0;
    if (r) begin
      m_rd = 64'd0;
      return e;
    end
    sz  = 1 << f3[1:0];
    ill = (mw && f3 > 3) || (mr && f3 == 7);
    mis = (a % sz) != 0;
    oor = a > 64'(DEPTH - sz);
    if (mr || mw) begin
      e.fi = ill;
      e.fa = !ill && mis;
      e.fr = !ill && !mis && oor;
    end
    flt = e.fi | e.fa | e.fr;
    if (mr) begin
      v = 64'd0;
      if (!flt) begin
        for (int i = 0; i < sz; i++) v = v | (64'(mmem[int'(a) + i]) << (8 * i));
        if (f3 < 3 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
      end
      m_rd = v;
    end
    e.rv = mr;
    e.rd = m_rd;
    if (mw && !flt) begin
      for (int i = 0; i < sz; i++) mmem[int'(a) + i] = wd[8*i +: 8];
    end
    return e;
  endfunction

  task automatic cyc(input logic r, input logic mr, input logic mw, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd,
                     input logic use_want = 1'b0, input logic [63:0] want = 64'd0);
    exp_t e;
    @(negedge clk);
    reset = r; MemRead = mr; MemWrite = mw; funct3 = f3; Mem_Addr = a; Write_Data = wd;
    e = model_step(r, mr, mw, f3, a, wd);
    if (use_want) e.rd = want;
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("read_valid", {63'd0, read_valid}, {63'd0, e.rv});
        chk("fault_align", {63'd0, fault_align}, {63'd0, e.fa});
        chk("fault_range", {63'd0, fault_range}, {63'd0, e.fr});
        chk("fault_illegal", {63'd0, fault_illegal}, {63'd0, e.fi});
        chk("Read_Data", Read_Data, e.rd);
      end
    end
  end

  initial begin : stimulus
    logic [63:0] a;
    logic [2:0]  f3;
    int          szr;
    int          waited;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 8'd0;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    for (int w = 0; w < DEPTH / 8; w++) cyc(1'b0, 1'b0, 1'b1, 3'd3, 64'(w * 8), {$urandom, $urandom});
    idle();

    cyc(1'b0, 1'b0, 1'b1, 3'd3, 64'h100, 64'h1122334455667788);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h100, 64'd0, 1'b1, 64'h1122334455667788);
    idle();

    cyc(1'b0, 1'b0, 1'b1, 3'd0, 64'h108, 64'h80);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 64'h108, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 64'h108, 64'd0, 1'b1, 64'h0000000000000080);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h108, 64'd0);

    cyc(1'b0, 1'b0, 1'b1, 3'd2, 64'h104, 64'hDEADBEEF);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h100, 64'd0, 1'b1, 64'hDEADBEEF55667788);
    cyc(1'b0, 1'b1, 1'b0, 3'd6, 64'h104, 64'd0, 1'b1, 64'h00000000DEADBEEF);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 64'h102, 64'd0, 1'b1, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 64'h101, 64'hFFFF);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h100, 64'd0, 1'b1, 64'hDEADBEEF55667788);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h1FC, 64'd0, 1'b1, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'd4, 64'h100, ~64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h100, 64'd0, 1'b1, 64'hDEADBEEF55667788);
    cyc(1'b0, 1'b1, 1'b0, 3'd7, 64'h100, 64'd0, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h1F8, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 64'h200, 64'd0, 1'b1, 64'd0);
    idle();

    cyc(1'b0, 1'b0, 1'b1, 3'd3, 64'h110, 64'h5);
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 64'h110, 64'hAA, 1'b1, 64'h5);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h110, 64'd0, 1'b1, 64'hAA);
    cyc(1'b0, 1'b1, 1'b1, 3'd4, 64'h110, 64'hBB, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h110, 64'd0, 1'b1, 64'hAA);

    cyc(1'b1, 1'b0, 1'b1, 3'd3, 64'h118, 64'h1234);
    cyc(1'b1, 1'b1, 1'b0, 3'd3, 64'h118, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 64'h118, 64'd0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      f3  = 3'($urandom_range(0, 7));
      szr = 1 << f3[1:0];
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 64'h100 + 64'($urandom_range(0, 63));
        6:                a = 64'($urandom_range(0, DEPTH - 1));
        7:                a = 64'h1F8 + 64'($urandom_range(0, 7));
        8:                a = {$urandom, $urandom};
        default:          a = 64'(DEPTH) + 64'($urandom_range(0, 7)) - 64'd8 + 64'($urandom_range(0, 1)) * 64'hFFFFFFFFFFFFFE00;
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~64'(szr - 1);
      if ($urandom_range(0, 4) == 0 && f3 > 3) f3 = {1'b0, f3[1:0]};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
          f3, a, {$urandom, $urandom});
    end
    idle();
    idle();

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
